// File: rtl/vu_pkg.sv
// rtl/vu_pkg.sv - shared colours, pixel type and zone defaults for the VU bar renderer
package vu_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam rgb332_t BLACK  = 8'b000_000_00;
    localparam rgb332_t GREEN  = 8'b000_111_00;
    localparam rgb332_t YELLOW = 8'b111_111_00;
    localparam rgb332_t RED    = 8'b111_000_00;
    localparam rgb332_t WHITE  = 8'b111_111_11;
    localparam rgb332_t GREY   = 8'b010_010_01;

    localparam int DEF_GREEN_END  = 448;
    localparam int DEF_YELLOW_END = 576;

endpackage

// File: rtl/vu_bar_renderer_if.sv
// rtl/vu_bar_renderer_if.sv - level, timing and RGB332 pixel signals of the VU bar renderer
// master: meter front-end / timing side, drives level and position, receives pixel colour
// slave : renderer, consumes level and position, drives red/green/blue
interface vu_bar_renderer_if #(
    parameter int POS_W = 10,
    parameter int LVL_W = 10
);
    logic [LVL_W-1:0] level_in;
    logic             level_valid;
    logic             frame_start;
    logic             de;
    logic [POS_W-1:0] h_pos;
    logic [POS_W-1:0] v_pos;
    logic [2:0]       red;
    logic [2:0]       green;
    logic [1:0]       blue;

    modport master (
        output level_in, level_valid, frame_start, de, h_pos, v_pos,
        input  red, green, blue
    );

    modport slave (
        input  level_in, level_valid, frame_start, de, h_pos, v_pos,
        output red, green, blue
    );
endinterface

// File: rtl/vu_peak_hold.sv
// rtl/vu_peak_hold.sv - peak-hold register with hold timer and linear decay, updated per frame
// Ports:
//   pixel_clock  in   clock
//   reset        in   synchronous, active-high
//   frame_start  in   one-cycle frame pulse; the only cycle in which state changes
//   level        in   effective (saturated) level of the frame being started
//   peak         out  current peak position in pixels
module vu_peak_hold #(
    parameter int LVL_W       = 10,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY_STEP  = 4
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] peak
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [LVL_W:0]    peak_w;
    logic [LVL_W:0]    floor_w;
    logic [LVL_W-1:0]  decayed;

    // One extra bit so peak-DECAY_STEP cannot wrap: if the peak is closer to
    // the level than one step, it lands exactly on the level.
    assign peak_w  = {1'b0, peak};
    assign floor_w = {1'b0, level} + (LVL_W + 1)'(DECAY_STEP);
    assign decayed = (peak_w < floor_w) ? level
                                        : LVL_W'(peak_w - (LVL_W + 1)'(DECAY_STEP));

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            peak     <= '0;
            hold_cnt <= '0;
        end else if (frame_start) begin
            if (level >= peak) begin
                peak     <= level;
                hold_cnt <= HOLD_W'(HOLD_FRAMES);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end else begin
                peak <= decayed;
            end
        end
    end

endmodule

// File: rtl/vu_bar_renderer.sv
// rtl/vu_bar_renderer.sv - RGB332 horizontal VU bar with colour zones, unlit track and peak marker
// Optional feature macro: VU_PEAK_HOLD_EN (peak-hold marker; absent when undefined)
// Ports:
//   pixel_clock  in   pixel clock, only clock
//   reset        in   synchronous, active-high
//   bus          slave modport of vu_bar_renderer_if:
//                level_in/level_valid  meter level in pixels and its strobe
//                frame_start           first cycle of each frame
//                de/h_pos/v_pos        display enable and active-area position
//                red/green/blue        registered pixel colour, 1 cycle after position
module vu_bar_renderer
    import vu_pkg::*;
#(
    parameter int H_ACT       = 640,
    parameter int POS_W       = 10,
    parameter int LVL_W       = 10,
    parameter int BAR_Y0      = 200,
    parameter int BAR_H       = 80,
    parameter int GREEN_END   = DEF_GREEN_END,
    parameter int YELLOW_END  = DEF_YELLOW_END,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY_STEP  = 4,
    parameter int PEAK_W      = 2
) (
    input  logic             pixel_clock,
    input  logic             reset,
    vu_bar_renderer_if.slave bus
);

    logic [LVL_W-1:0] sat_lvl;
    logic [LVL_W-1:0] eff_lvl;
    logic [LVL_W-1:0] pending_lvl;
    logic [LVL_W-1:0] disp_lvl;
    logic             disp_on;
    rgb332_t          pix;
    rgb332_t          rgb_q;

    logic [31:0] hx;
    logic [31:0] vy;
    logic [31:0] lit;
    logic        in_rows;

    assign sat_lvl = (32'(bus.level_in) > 32'(H_ACT)) ? LVL_W'(H_ACT) : bus.level_in;
    // A level arriving together with frame_start is used for that frame directly.
    assign eff_lvl = bus.level_valid ? sat_lvl : pending_lvl;

    assign hx      = 32'(bus.h_pos);
    assign vy      = 32'(bus.v_pos);
    assign lit     = 32'(disp_lvl);
    assign in_rows = (vy >= 32'(BAR_Y0)) && (vy < 32'(BAR_Y0 + BAR_H));

`ifdef VU_PEAK_HOLD_EN
    logic [LVL_W-1:0] peak;
    logic [31:0]      pk;
    logic             on_marker;

    vu_peak_hold #(
        .LVL_W       (LVL_W),
        .HOLD_FRAMES (HOLD_FRAMES),
        .DECAY_STEP  (DECAY_STEP)
    ) u_peak_hold (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .frame_start (bus.frame_start),
        .level       (eff_lvl),
        .peak        (peak)
    );

    assign pk        = 32'(peak);
    assign on_marker = (pk >= 32'(PEAK_W)) && (hx + 32'(PEAK_W) >= pk) && (hx < pk);
`endif

    always_comb begin
        pix = GREY;
        // disp_on blanks the bar after reset until the first frame has been latched.
        if (!disp_on || !bus.de || !in_rows) begin
            pix = BLACK;
`ifdef VU_PEAK_HOLD_EN
        end else if (on_marker) begin
            pix = WHITE;
`endif
        end else if (hx < lit) begin
            if (hx < 32'(GREEN_END)) begin
                pix = GREEN;
            end else if (hx < 32'(YELLOW_END)) begin
                pix = YELLOW;
            end else begin
                pix = RED;
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            pending_lvl <= '0;
            disp_lvl    <= '0;
            disp_on     <= 1'b0;
            rgb_q       <= BLACK;
        end else begin
            if (bus.level_valid) begin
                pending_lvl <= sat_lvl;
            end
            if (bus.frame_start) begin
                disp_lvl <= eff_lvl;
                disp_on  <= 1'b1;
            end
            rgb_q <= pix;
        end
    end

    assign bus.red   = rgb_q.r;
    assign bus.green = rgb_q.g;
    assign bus.blue  = rgb_q.b;

endmodule

// File: tb/tb_vu_bar_renderer.sv
// tb/tb_vu_bar_renderer.sv - randomized and directed self-checking bench for vu_bar_renderer
module tb_vu_bar_renderer;

`ifdef VU_PEAK_HOLD_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    localparam logic [7:0] C_BLACK  = 8'h00;
    localparam logic [7:0] C_GREEN  = 8'b000_111_00;
    localparam logic [7:0] C_YELLOW = 8'b111_111_00;
    localparam logic [7:0] C_RED    = 8'b111_000_00;
    localparam logic [7:0] C_WHITE  = 8'hFF;
    localparam logic [7:0] C_GREY   = 8'b010_010_01;

    logic pixel_clock = 1'b0;
    logic reset       = 1'b1;

    always #5 pixel_clock = ~pixel_clock;

    vu_bar_renderer_if #(.POS_W(10), .LVL_W(10)) bus ();

    vu_bar_renderer dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, tracked as plain integers.
    int m_pend = 0;
    int m_disp = 0;
    int m_peak = 0;
    int m_hold = 0;
    bit m_on   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_pixel(input bit d, input int h, input int v);
        if (!m_on || !d || v < 200 || v > 279) return C_BLACK;
        if (PEAK_EN && m_peak >= 2 && h >= m_peak - 2 && h <= m_peak - 1) return C_WHITE;
        if (h < m_disp) begin
            if (h < 448) return C_GREEN;
            if (h < 576) return C_YELLOW;
            return C_RED;
        end
        return C_GREY;
    endfunction

    // One pixel cycle: apply inputs, clock, compare against the model (and an
    // optional hand-computed constant), then advance the model for that edge.
    task automatic cyc(input bit rst, input int lvl, input bit lv, input bit fs,
                       input bit d, input int h, input int v, input string tag,
                       input int want = -1);
        logic [7:0] exp;
        logic [7:0] got;
        int sat;
        int eff;
        reset           = rst;
        bus.level_in    = 10'(lvl);
        bus.level_valid = lv;
        bus.frame_start = fs;
        bus.de          = d;
        bus.h_pos       = 10'(h);
        bus.v_pos       = 10'(v);
        exp = rst ? C_BLACK : ref_pixel(d, h, v);
        @(posedge pixel_clock);
        #1;
        got = {bus.red, bus.green, bus.blue};
        check(tag, 32'(got), 32'(exp));
        if (want >= 0) check({tag, "_const"}, 32'(got), 32'(want));
        if (rst) begin
            m_pend = 0; m_disp = 0; m_peak = 0; m_hold = 0; m_on = 1'b0;
        end else begin
            sat = (lvl > 640) ? 640 : lvl;
            eff = lv ? sat : m_pend;
            if (lv) m_pend = sat;
            if (fs) begin
                m_disp = eff;
                m_on   = 1'b1;
                if (eff >= m_peak) begin
                    m_peak = eff;
                    m_hold = 30;
                end else if (m_hold > 0) begin
                    m_hold = m_hold - 1;
                end else begin
                    m_peak = (m_peak - 4 < eff) ? eff : m_peak - 4;
                end
            end
        end
    endtask

    task automatic new_frame(input int lvl, input bit lv);
        cyc(1'b0, lvl, lv, 1'b1, 1'b0, 0, 0, "fs");
    endtask

    int pk_exp;
    int want;

    initial begin
        bus.level_in = '0; bus.level_valid = 1'b0; bus.frame_start = 1'b0;
        bus.de = 1'b0; bus.h_pos = '0; bus.v_pos = '0;

        // Reset held three cycles with an active pixel, then blank until frame_start.
        for (int i = 0; i < 3; i++) cyc(1'b1, 0, 1'b0, 1'b0, 1'b1, 10 + i, 220, "reset", C_BLACK);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 10 + i, 220, "pre_frame", C_BLACK);

        // Basic bar at level 300.
        cyc(1'b0, 300, 1'b1, 1'b0, 1'b0, 0, 0, "lvl300");
        new_frame(0, 1'b0);
        for (int x = 0; x < 640; x++) begin
            if (x < 298)       want = C_GREEN;
            else if (x < 300)  want = PEAK_EN ? C_WHITE : C_GREEN;
            else               want = C_GREY;
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, x, 220, "basic", want);
        end
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 100, 199, "row199", C_BLACK);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 100, 280, "row280", C_BLACK);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 100, 220, "de_low", C_BLACK);

        // Saturation and colour zones.
        new_frame(700, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 447, 220, "z447", C_GREEN);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 448, 220, "z448", C_YELLOW);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 575, 220, "z575", C_YELLOW);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 576, 220, "z576", C_RED);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 637, 220, "z637", C_RED);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 638, 220, "z638", PEAK_EN ? C_WHITE : C_RED);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 639, 220, "z639", PEAK_EN ? C_WHITE : C_RED);

        // Peak hold and decay: one frame at 300, then 80 frames at 100.
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0, "rst2", C_BLACK);
        new_frame(300, 1'b1);
        for (int k = 1; k <= 80; k++) begin
            new_frame(100, 1'b1);
            pk_exp = (k <= 30) ? 300 : ((300 - 4 * (k - 30) < 100) ? 100 : 300 - 4 * (k - 30));
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, pk_exp - 1, 240, "mark_hi",
                PEAK_EN ? int'(C_WHITE) : ((pk_exp - 1 < 100) ? int'(C_GREEN) : int'(C_GREY)));
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, pk_exp - 2, 240, "mark_lo",
                PEAK_EN ? int'(C_WHITE) : ((pk_exp - 2 < 100) ? int'(C_GREEN) : int'(C_GREY)));
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, pk_exp, 240, "mark_past", C_GREY);
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 97, 240, "bar_97", C_GREEN);
        end
        // Peak has settled on the level and must stay there.
        new_frame(100, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 99, 240, "floor99", PEAK_EN ? C_WHITE : C_GREEN);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 100, 240, "floor100", C_GREY);

        // Bypass in the frame_start cycle, then a mid-frame update that must not tear.
        new_frame(500, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 497, 220, "bypass497", C_YELLOW);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 500, 220, "bypass500", C_GREY);
        cyc(1'b0, 50, 1'b1, 1'b0, 1'b1, 497, 220, "mid_lv", C_YELLOW);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 497, 220, "no_tear", C_YELLOW);
        new_frame(0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 49, 220, "new49", C_GREEN);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 50, 220, "new50", C_GREY);

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            new_frame($urandom_range(0, 1023), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 60; i++) begin
                cyc(1'b0, $urandom_range(0, 1023), ($urandom_range(0, 15) == 0),
                    1'b0, ($urandom_range(0, 7) != 0), $urandom_range(0, 639),
                    $urandom_range(180, 300), "rand");
            end
        end

        // Reset mid-frame: black and blank until the next frame_start.
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b1, 10, 220, "mid_rst", C_BLACK);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 10, 220, "post_rst", C_BLACK);
        new_frame(0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 10, 220, "resume", C_GREY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vu_bar_renderer.md
Name: vu_bar_renderer

Overview:
- Pixel-colour stage directly upstream of the VGA output stage.
- Takes the audio level from the meter front-end and the pixel position and display-enable from the timing counters.
- Produces RGB332 for a horizontal VU bar with green/yellow/red zones, a grey unlit track and a peak-hold marker.
- Level updates apply only at frame boundaries, so the bar never tears.

Parameters:
- H_ACT, 640: active pixels per line; also the maximum bar length in pixels.
- POS_W, 10: width of h_pos/v_pos.
- LVL_W, 10: width of level_in (unit = one pixel of bar length).
- BAR_Y0, 200: first active row of the bar.
- BAR_H, 80: bar height in rows.
- GREEN_END, 448: first x that is yellow.
- YELLOW_END, 576: first x that is red.
- HOLD_FRAMES, 30: frames the peak is held before decay starts.
- DECAY_STEP, 4: pixels the peak drops per frame during decay.
- PEAK_W, 2: peak marker width in pixels.

Ports:
- pixel_clock  in  1  pixel clock; only clock.
- reset  in  1  synchronous, active-high.
- level_in  in  LVL_W  new meter level, in pixels.
- level_valid  in  1  level_in is valid this cycle.
- frame_start  in  1  one-cycle pulse at the first cycle of each frame.
- de  in  1  display enable (active pixel).
- h_pos  in  POS_W  active-area x, 0..H_ACT-1.
- v_pos  in  POS_W  active-area y.
- red  out  3  pixel red.
- green  out  3  pixel green.
- blue  out  2  pixel blue.

Behaviour:
- Clock and reset: single clock, pixel_clock. reset is synchronous and active-high.
- Reset values: red, green and blue = 0. pending_lvl, disp_lvl, peak and hold_cnt = 0.
- Level capture:
  - On level_valid: pending_lvl <= min(level_in, H_ACT).
  - Several level_valid pulses within one frame: the last one wins.
- Frame update, on frame_start:
  - disp_lvl <= the effective pending value.
  - If level_valid is asserted in the same cycle, the effective value is the saturated level_in (bypass). Otherwise it is pending_lvl.
- Peak hold, evaluated on frame_start using the same effective value L:
  - If L >= peak: peak <= L, hold_cnt <= HOLD_FRAMES.
  - Else if hold_cnt != 0: hold_cnt <= hold_cnt-1.
  - Else: peak <= max(peak-DECAY_STEP, L), saturating at L, never below.
  - Arithmetic must not underflow; use an LVL_W+1 intermediate.
- Pixel classification, combinational on the inputs. Priority order:
  1. de=0, or v_pos outside [BAR_Y0, BAR_Y0+BAR_H-1]: black 000/000/00.
  2. Peak marker: peak >= PEAK_W and h_pos in [peak-PEAK_W, peak-1] → white 111/111/11.
  3. Lit bar: h_pos < disp_lvl, coloured by zone:
     - h_pos < GREEN_END: green 000/111/00.
     - h_pos < YELLOW_END: yellow 111/111/00.
     - otherwise: red 111/000/00.
  4. Unlit track: grey 010/010/01.
- Output timing:
  - Outputs are registered: exactly 1 cycle latency from h_pos/v_pos/de to red/green/blue.
  - Upstream timing compensates by advancing position one cycle.
- Frame-boundary behaviour: a frame_start edge changes disp_lvl and peak for pixels sampled from the next cycle onward. The pixel sampled in the frame_start cycle uses the old values.
- Boundary cases:
  - level 0: no lit pixels. A marker is drawn only while peak >= PEAK_W.
  - level_in > H_ACT: saturates to H_ACT, so the whole row is lit and the marker occupies x = H_ACT-PEAK_W .. H_ACT-1.
- Reset mid-frame: next cycle outputs black and all state is zero. Display resumes with the next frame_start.

Optional Feature:
- Macro: VU_PEAK_HOLD_EN.
- Defined: peak, hold_cnt and marker logic present, as described above.
- Undefined:
  - peak/hold registers are not instantiated and classification step 2 is removed.
  - Pixels in the marker position are coloured as bar or track.
  - All other behaviour is identical.

Decomposition:
- Package vu_pkg holds:
  - RGB332 colour constants: BLACK, GREEN, YELLOW, RED, WHITE, GREY.
  - A packed rgb332 typedef (r[2:0], g[2:0], b[1:0]).
  - Default zone threshold constants.
- Sub-module vu_peak_hold:
  - Owns peak, hold_cnt and the decay logic.
  - Inputs: pixel_clock, reset, frame_start, effective level.
  - Output: peak.
  - Instantiated only under VU_PEAK_HOLD_EN.

Test Plan:
- Reset check: reset held 3 cycles with de=1, v_pos=220 → rgb=0 throughout, and rgb=0 on the cycle after release until the first frame_start.
- Basic bar: level_in=300 + level_valid, then frame_start. Scan row 220 → x 0..297 green, x 298..299 white, x 300..639 grey. Row 199 and row 280 → black. Each output lags h_pos by one cycle.
- Zones: level_in=700 → saturates to 640. Row 220 → x=447 green, x=448 yellow, x=575 yellow, x=576 red, x 638..639 white.
- Peak hold and decay: level 300 for one frame, then level 100 every frame.
  - Marker stays at 298..299 for 30 frames.
  - Peak then falls by 4 per frame, reaching 100 after 50 further frames, and never goes below 100.
  - Lit bar ends at x=99 from the first level-100 frame.
- Bypass and tear-free update:
  - level_valid with 500 in the same cycle as frame_start → disp_lvl=500 immediately.
  - level_valid with 50 mid-frame → bar unchanged until the next frame_start.
- Feature off (VU_PEAK_HOLD_EN undefined): level 300 → x 298..299 green, not white. Other pixels identical to the basic-bar test.
